// File: rtl/arith_bound_accum.sv
// Bounded x/y accumulator with start/clear handshake, three accumulation modes,
// saturating sum, sticky overflow and RUN-cycle counter. Optional assertions: ARITH_BOUND_ASSERT_EN.
module arith_bound_accum #(
  parameter int W      = 16,
  parameter int LIMIT  = 200,
  parameter int X_INIT = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         clear,
  input  logic         selector,
  input  logic [1:0]   mode,
  output logic [W-1:0] x,
  output logic [W-1:0] y,
  output logic [W-1:0] cycles,
  output logic         busy,
  output logic         done,
  output logic         overflow
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [W-1:0] XI   = W'(X_INIT);
  localparam logic [W-1:0] LIM  = W'(LIMIT);
  localparam logic [W-1:0] MAXV = '1;
  localparam int SW = 2*W + 1;

  state_t       state;
  logic [1:0]   mode_q;
  logic [SW-1:0] f, sum;
  logic         step, sat;

  // f(y) and the sum are formed wide enough that nothing wraps before saturation
  always_comb begin
    f = '0;
    case (mode_q)
      2'b00:   f = SW'(y);
      2'b01:   f = SW'(y) << 1;
      2'b10:   f = SW'(y) * SW'(y);
      default: f = '0;
    endcase
    sum  = SW'(x) + f;
    sat  = sum > SW'(MAXV);
    step = selector && (y < LIM) && (mode_q != 2'b11);
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      mode_q   <= 2'b00;
      x        <= XI;
      y        <= '0;
      cycles   <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      state    <= IDLE;
      x        <= XI;
      y        <= '0;
      cycles   <= '0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state    <= RUN;
            mode_q   <= mode;
            x        <= XI;
            y        <= '0;
            cycles   <= '0;
            overflow <= 1'b0;
          end
        end
        RUN: begin
          if (cycles != MAXV) cycles <= cycles + 1'b1;
          if (step) begin
            x <= sat ? MAXV : sum[W-1:0];
            y <= y + 1'b1;
            if (sat) overflow <= 1'b1;
            if (y == LIM - W'(1)) state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ARITH_BOUND_ASSERT_EN
  a_x_ge_y:   assert property (@(posedge clk) disable iff (rst) !((y >= LIM) && (x < y)));
  a_y_le_lim: assert property (@(posedge clk) disable iff (rst) y <= LIM);
  a_done_lim: assert property (@(posedge clk) disable iff (rst) done |-> (y == LIM));
  a_excl:     assert property (@(posedge clk) disable iff (rst) !(busy && done));
  a_ovf_max:  assert property (@(posedge clk) disable iff (rst) overflow |-> (x == MAXV));
`endif

endmodule

// File: tb/tb_arith_bound_accum.sv
// Random + directed bench for arith_bound_accum against an integer reference model.
module tb_arith_bound_accum;
  localparam int W = 16, LIMIT = 200, X_INIT = 1, MAXV = 65535;

  logic clk = 0, rst, start, clear, selector;
  logic [1:0] mode;
  logic [W-1:0] x, y, cycles;
  logic busy, done, overflow;

  int vectors = 0, miscompares = 0;

  // reference model state: phase 0=idle 1=run 2=done
  int m_phase, m_x, m_y, m_cyc, m_ov, m_mode;

  arith_bound_accum #(.W(W), .LIMIT(LIMIT), .X_INIT(X_INIT)) dut (
    .clk(clk), .rst(rst), .start(start), .clear(clear), .selector(selector),
    .mode(mode), .x(x), .y(y), .cycles(cycles), .busy(busy), .done(done),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int fy, t;
    if (rst) begin
      m_phase = 0; m_x = X_INIT; m_y = 0; m_cyc = 0; m_ov = 0; m_mode = 0;
    end else if (clear) begin
      m_phase = 0; m_x = X_INIT; m_y = 0; m_cyc = 0; m_ov = 0;
    end else if (m_phase != 1) begin
      if (start) begin
        m_phase = 1; m_x = X_INIT; m_y = 0; m_cyc = 0; m_ov = 0; m_mode = int'(mode);
      end
    end else begin
      if (m_cyc < MAXV) m_cyc++;
      if (selector && m_y < LIMIT && m_mode != 3) begin
        fy = (m_mode == 0) ? m_y : (m_mode == 1) ? 2 * m_y : m_y * m_y;
        t = m_x + fy;
        if (t > MAXV) begin m_x = MAXV; m_ov = 1; end
        else m_x = t;
        m_y++;
        if (m_y == LIMIT) m_phase = 2;
      end
    end
  endtask

  task automatic cyc(input logic r, input logic st, input logic cl,
                     input logic sel, input logic [1:0] md);
    rst = r; start = st; clear = cl; selector = sel; mode = md;
    @(posedge clk);
    model_step();
    #1;
    vectors++;
    if (int'(x) != m_x || int'(y) != m_y || int'(cycles) != m_cyc ||
        busy != (m_phase == 1) || done != (m_phase == 2) || overflow != (m_ov != 0)) begin
      miscompares++;
      $display("FAIL model: got x=%0d y=%0d cyc=%0d b=%0b d=%0b ov=%0b expected x=%0d y=%0d cyc=%0d ph=%0d ov=%0d",
               x, y, cycles, busy, done, overflow, m_x, m_y, m_cyc, m_phase, m_ov);
    end
  endtask

  // start a run, then clock with selector pattern until done; returns edges incl. start edge
  task automatic run(input logic [1:0] md, input bit alt, output int edges);
    edges = 1;
    cyc(0, 1, 0, 1, md);
    while (!done && edges < 1000) begin
      cyc(0, 0, 0, alt ? edges[0] : 1'b1, md);
      edges++;
    end
    check("done_timeout", int'(done), 1);
  endtask

  initial begin
    int n;
    cyc(1, 0, 0, 0, 2'b00);
    cyc(1, 1, 0, 1, 2'b10);
    check("rst_x", int'(x), 1);
    check("rst_y", int'(y), 0);
    check("rst_flags", {busy, done, overflow}, 0);

    run(2'b00, 0, n);
    check("lin_edges", n, 201);
    check("lin_x", int'(x), 19901);
    check("lin_y", int'(y), 200);
    check("lin_cycles", int'(cycles), 200);
    check("lin_ov", int'(overflow), 0);
    cyc(0, 0, 0, 1, 2'b00);
    check("done_hold_x", int'(x), 19901);

    run(2'b01, 0, n);
    check("dbl_x", int'(x), 39801);
    check("dbl_ov", int'(overflow), 0);

    run(2'b10, 0, n);
    check("sq_x", int'(x), 65535);
    check("sq_ov", int'(overflow), 1);
    check("sq_y", int'(y), 200);

    cyc(0, 1, 0, 0, 2'b00);
    check("restart_ov", int'(overflow), 0);
    check("restart_busy", int'(busy), 1);
    cyc(0, 0, 1, 0, 2'b00);

    run(2'b00, 1, n);
    check("alt_x", int'(x), 19901);
    check("alt_cycles", (cycles == 399 || cycles == 400) ? 1 : 0, 1);

    cyc(0, 1, 0, 1, 2'b00);
    for (int i = 0; i < 300 && y != 50; i++) cyc(0, 0, 0, 1, 2'b00);
    check("pre_clear_y", int'(y), 50);
    cyc(0, 0, 1, 1, 2'b00);
    check("clear_x", int'(x), 1);
    check("clear_y", int'(y), 0);
    check("clear_flags", {busy, done}, 0);
    cyc(0, 1, 1, 1, 2'b00);
    check("collide_busy", int'(busy), 0);

    cyc(0, 1, 0, 1, 2'b11);
    for (int i = 0; i < 1000; i++) cyc(0, 0, 0, 1, 2'b11);
    check("hold_x", int'(x), 1);
    check("hold_y", int'(y), 0);
    check("hold_cycles", int'(cycles), 1000);
    check("hold_busy", int'(busy), 1);
    cyc(1, 0, 0, 1, 2'b11);
    check("midrst_cycles", int'(cycles), 0);
    check("midrst_busy", int'(busy), 0);

    for (int i = 0; i < 6000; i++) begin
      logic st, cl, r;
      r  = ($urandom_range(0, 499) == 0);
      cl = ($urandom_range(0, 299) == 0);
      st = ($urandom_range(0, 9) == 0);
      cyc(r, st, cl, $urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
